// File: rtl/rv_pkg.sv
// Shared RISC-V core types and constants.
// Fetch additions: NOP encoding, fetch FSM states and the fetch entry bundle.
package rv_pkg;

  localparam int RV_INSTR_W = 32;
  localparam logic [RV_INSTR_W-1:0] RV_NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_RUN,
    FETCH_DRAIN
  } fetch_state_e;

  typedef struct packed {
    logic [RV_INSTR_W-1:0] instr;
    logic [31:0]           pc;
  } fetch_entry_t;

endpackage

// File: rtl/rv_fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush, count, full and empty.
// Same-cycle push and pop are allowed, including when full.
module rv_fetch_fifo
  import rv_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  fetch_entry_t  wdata_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output fetch_entry_t  rdata_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam fetch_entry_t RST_ENTRY = '{
    instr: RV_NOP_INSTR,
    pc:    32'h0
  };

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (cnt == CW'(DEPTH));
  assign empty_o = (cnt == '0);
  assign count_o = cnt;
  assign rdata_o = mem[rptr];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Storage: written only on an accepted push, never bypassed to the head.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= RST_ENTRY;
      end
    end else if (!flush_i && do_push) begin
      mem[wptr] <= wdata_i;
    end
  end

  // Pointers and occupancy; flush empties the queue in one cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (flush_i) begin
      rptr <= wptr;
      cnt  <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + AW'(1);
      end
      if (do_pop) begin
        rptr <= rptr + AW'(1);
      end
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/rv_fetch.sv
// Instruction fetch unit: sequential PC generation, credit-limited requests,
// in-order response buffering, redirect flush/drain. Option: RV_FETCH_PERF_EN.
module rv_fetch
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o
`ifdef RV_FETCH_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt_o,
  output logic [31:0] perf_redirect_cnt_o
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = CW + 1;

  fetch_state_e  state_q;
  fetch_state_e  state_d;
  logic [31:0]   fetch_pc_q;
  logic [31:0]   fetch_pc_d;

  logic [CW-1:0] out_cnt;
  logic [CW-1:0] out_next;
  logic [CW-1:0] buf_cnt;
  logic [SW-1:0] used;
  logic          credit_ok;
  logic          gnt_fire;
  logic          rsp_fire;
  logic          rsp_keep;
  logic          out_fire;

  fetch_entry_t  pcq_head;
  fetch_entry_t  pcq_wdata;
  fetch_entry_t  buf_head;
  fetch_entry_t  buf_wdata;
  logic          pcq_full;
  logic          pcq_empty;
  logic          buf_full;
  logic          buf_empty;
  logic          unused_sig;

  assign used      = {1'b0, out_cnt} + {1'b0, buf_cnt};
  assign credit_ok = (used < SW'(FIFO_DEPTH));

  assign imem_req_o  = (state_q == FETCH_RUN) && credit_ok && !redirect_i;
  assign imem_addr_o = fetch_pc_q;

  assign gnt_fire = imem_req_o && imem_gnt_i;
  assign rsp_fire = imem_rvalid_i && !pcq_empty;
  assign rsp_keep = rsp_fire && (state_q == FETCH_RUN) && !redirect_i;
  assign out_fire = instr_valid_o && instr_ready_i;
  assign out_next = out_cnt - CW'(rsp_fire);

  assign pcq_wdata = '{instr: '0, pc: fetch_pc_q};
  assign buf_wdata = '{instr: imem_rdata_i, pc: pcq_head.pc};

  assign instr_valid_o = !buf_empty;
  assign instr_o       = buf_head.instr;
  assign instr_pc_o    = buf_head.pc;

  assign unused_sig = ^{pcq_full, buf_full, pcq_head.instr};

  rv_fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_pcq (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (gnt_fire),
    .wdata_i (pcq_wdata),
    .pop_i   (rsp_fire),
    .flush_i (1'b0),
    .rdata_o (pcq_head),
    .count_o (out_cnt),
    .full_o  (pcq_full),
    .empty_o (pcq_empty)
  );

  rv_fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_buf (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (rsp_keep),
    .wdata_i (buf_wdata),
    .pop_i   (out_fire),
    .flush_i (redirect_i),
    .rdata_o (buf_head),
    .count_o (buf_cnt),
    .full_o  (buf_full),
    .empty_o (buf_empty)
  );

  // State and fetch PC registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= FETCH_IDLE;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  // Next state and PC; a redirect overrides everything else.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    if (redirect_i) begin
      fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
      if (state_q == FETCH_DRAIN || out_next != '0) begin
        state_d = FETCH_DRAIN;
      end else begin
        state_d = FETCH_RUN;
      end
    end else begin
      unique case (state_q)
        FETCH_IDLE: begin
          state_d = FETCH_RUN;
        end
        FETCH_RUN: begin
          if (gnt_fire) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
          end
        end
        FETCH_DRAIN: begin
          if (out_next == '0) begin
            state_d = FETCH_RUN;
          end
        end
        default: begin
          state_d = FETCH_IDLE;
        end
      endcase
    end
  end

  // A response with nothing in flight means the memory broke ordering.
  rsp_without_req: assert property (
    @(posedge clk_i) disable iff (rst_i)
    imem_rvalid_i |-> (out_cnt != '0)
  );

`ifdef RV_FETCH_PERF_EN
  // Decode-starved cycles and redirect events, both free-running.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_stall_cnt_o    <= '0;
      perf_redirect_cnt_o <= '0;
    end else begin
      if (instr_ready_i && !instr_valid_o && state_q != FETCH_IDLE) begin
        perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
      end
      if (redirect_i) begin
        perf_redirect_cnt_o <= perf_redirect_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rv_fetch.sv
// Directed bench for rv_fetch: reset, streaming, backpressure, grant stall,
// redirect with drain, redirect on handshake, address wrap, perf counters.
module tb_rv_fetch;

  logic        clk;
  logic        rst;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        redir;
  logic [31:0] redir_pc;
  logic        ivalid;
  logic        irdy;
  logic [31:0] instr;
  logic [31:0] ipc;
  logic        resp_en;
`ifdef RV_FETCH_PERF_EN
  logic [31:0] perf_stall;
  logic [31:0] perf_redir;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] mq [$];
  logic        g_smp;
  logic [31:0] a_smp;
  logic        rv_smp;
  logic [31:0] dq_pc [$];
  logic [31:0] dq_in [$];
  int          gcount;
`ifdef RV_FETCH_PERF_EN
  int          since;
  logic [31:0] st_m;
  logic [31:0] rd_m;
`endif

  rv_fetch #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .imem_req_o    (req),
    .imem_addr_o   (addr),
    .imem_gnt_i    (gnt),
    .imem_rvalid_i (rvalid),
    .imem_rdata_i  (rdata),
    .redirect_i    (redir),
    .redirect_pc_i (redir_pc),
    .instr_valid_o (ivalid),
    .instr_ready_i (irdy),
    .instr_o       (instr),
    .instr_pc_o    (ipc)
`ifdef RV_FETCH_PERF_EN
    ,
    .perf_stall_cnt_o    (perf_stall),
    .perf_redirect_cnt_o (perf_redir)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] dat(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  // Sample the bus halfway through each cycle.
  always @(negedge clk) begin
    g_smp  = req && gnt;
    a_smp  = addr;
    rv_smp = rvalid;
    if (rst) begin
      gcount = 0;
      dq_pc.delete();
      dq_in.delete();
    end else begin
      if (req && gnt) gcount++;
      if (ivalid && irdy) begin
        dq_pc.push_back(ipc);
        dq_in.push_back(instr);
      end
    end
  end

`ifdef RV_FETCH_PERF_EN
  always @(negedge clk) begin
    if (rst) begin
      since = 0;
      st_m  = '0;
      rd_m  = '0;
    end else begin
      if (since > 0 && irdy && !ivalid) st_m++;
      if (redir) rd_m++;
      since++;
    end
  end
`endif

  // In-order memory: answers one cycle after grant while resp_en is set.
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      if (rv_smp && mq.size() > 0) void'(mq.pop_front());
      if (g_smp) mq.push_back(a_smp);
      if (resp_en && mq.size() > 0) begin
        rvalid <= 1'b1;
        rdata  <= dat(mq[0]);
      end else begin
        rvalid <= 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic look();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input logic r, input logic g, input logic s);
    tick();
    rst     = 1'b1;
    redir   = 1'b0;
    irdy    = r;
    gnt     = g;
    resp_en = s;
    look();
    tick();
    look();
    tick();
    rst = 1'b0;
    look();
  endtask

  task automatic run_until(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (dq_pc.size() < n && k < budget) begin
      tick();
      look();
      k++;
    end
    chk(tag, (dq_pc.size() >= n) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic check_seq(input string tag, input logic [31:0] base,
                           input int n);
    for (int i = 0; i < n && i < dq_pc.size(); i++) begin
      logic [31:0] e;
      e = base + 32'(4 * i);
      chk({tag, "_pc"}, dq_pc[i], e);
      chk({tag, "_dat"}, dq_in[i], dat(e));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    gnt      = 1'b0;
    resp_en  = 1'b0;
    irdy     = 1'b0;
    redir    = 1'b0;
    redir_pc = '0;
    tick();
    look();
    tick();
    look();
    chk("rst_req", req, 0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_valid", ivalid, 0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_pc", ipc, 32'h0);

    // Streaming with an always-ready decoder.
    tick();
    rst     = 1'b0;
    irdy    = 1'b1;
    gnt     = 1'b1;
    resp_en = 1'b1;
    look();
    chk("s1_idle_req", req, 0);
    tick();
    look();
    chk("s1_c1_req", req, 1);
    chk("s1_c1_addr", addr, 32'h0);
    chk("s1_c1_valid", ivalid, 0);
    tick();
    look();
    chk("s1_c2_req", req, 1);
    chk("s1_c2_addr", addr, 32'h4);
    chk("s1_c2_valid", ivalid, 0);
    tick();
    look();
    chk("s1_c3_valid", ivalid, 1);
    chk("s1_c3_pc", ipc, 32'h0);
    chk("s1_c3_instr", instr, dat(32'h0));
    run_until("s1_timeout", 6, 40);
    check_seq("s1", 32'h0, 6);

    // Decoder stalled for 10 cycles.
    do_reset(1'b0, 1'b1, 1'b1);
    repeat (10) begin
      tick();
      look();
    end
    chk("s2_grants", 32'(gcount), 32'd2);
    chk("s2_req", req, 0);
    chk("s2_valid", ivalid, 1);
    chk("s2_pc", ipc, 32'h0);
    chk("s2_instr", instr, dat(32'h0));
    tick();
    irdy = 1'b1;
    look();
    run_until("s2_timeout", 6, 40);
    check_seq("s2", 32'h0, 6);

    // Memory refuses grants for 5 cycles.
    do_reset(1'b1, 1'b0, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      tick();
      look();
      chk("s3_req_hold", req, 1);
      chk("s3_addr_hold", addr, 32'h0);
    end
    tick();
    gnt = 1'b1;
    look();
    run_until("s3_timeout", 3, 40);
    check_seq("s3", 32'h0, 3);

    // Redirect with two responses still in flight.
    do_reset(1'b1, 1'b1, 1'b0);
    tick();
    look();
    chk("s4_c1_addr", addr, 32'h0);
    tick();
    look();
    chk("s4_c2_addr", addr, 32'h4);
    tick();
    redir    = 1'b1;
    redir_pc = 32'h0000_0103;
    look();
    chk("s4_redir_req", req, 0);
    tick();
    redir   = 1'b0;
    resp_en = 1'b1;
    look();
    chk("s4_drain_req0", req, 0);
    chk("s4_drain_addr", addr, 32'h100);
    chk("s4_drain_valid0", ivalid, 0);
    tick();
    look();
    chk("s4_drain_req1", req, 0);
    chk("s4_drain_valid1", ivalid, 0);
    tick();
    look();
    chk("s4_drain_req2", req, 0);
    chk("s4_drain_valid2", ivalid, 0);
    tick();
    look();
    chk("s4_run_req", req, 1);
    chk("s4_run_addr", addr, 32'h100);
    run_until("s4_timeout", 2, 40);
    check_seq("s4", 32'h100, 2);

    // Redirect coinciding with a handshake and a response.
    do_reset(1'b0, 1'b1, 1'b1);
    repeat (3) begin
      tick();
      look();
    end
    tick();
    irdy = 1'b1;
    look();
    chk("s5_c4_pc", ipc, 32'h0);
    tick();
    irdy = 1'b0;
    look();
    chk("s5_c5_pc", ipc, 32'h4);
    chk("s5_c5_addr", addr, 32'h8);
    tick();
    irdy     = 1'b1;
    redir    = 1'b1;
    redir_pc = 32'h0000_0200;
    look();
    chk("s5_c6_valid", ivalid, 1);
    chk("s5_c6_rvalid", rvalid, 1);
    tick();
    redir = 1'b0;
    look();
    chk("s5_c7_valid", ivalid, 0);
    chk("s5_c7_req", req, 1);
    chk("s5_c7_addr", addr, 32'h200);
    run_until("s5_timeout", 3, 40);
    check_seq("s5", 32'h0, 2);
    if (dq_pc.size() >= 3) begin
      chk("s5_new_pc", dq_pc[2], 32'h200);
      chk("s5_new_dat", dq_in[2], dat(32'h200));
    end

    // Address wrap at the top of the space.
    do_reset(1'b1, 1'b1, 1'b1);
    tick();
    redir    = 1'b1;
    redir_pc = 32'hFFFF_FFFA;
    look();
    chk("s6_redir_req", req, 0);
    tick();
    redir = 1'b0;
    look();
    chk("s6_c2_addr", addr, 32'hFFFF_FFF8);
    tick();
    look();
    chk("s6_c3_addr", addr, 32'hFFFF_FFFC);
    tick();
    look();
    chk("s6_c4_req", req, 0);
    chk("s6_c4_pc", ipc, 32'hFFFF_FFF8);
    tick();
    look();
    chk("s6_c5_req", req, 1);
    chk("s6_c5_addr", addr, 32'h0);
    run_until("s6_timeout", 3, 40);
    check_seq("s6", 32'hFFFF_FFF8, 3);

`ifdef RV_FETCH_PERF_EN
    tick();
    irdy = 1'b0;
    look();
    chk("perf_stall", perf_stall, st_m);
    chk("perf_redir_model", perf_redir, rd_m);
    chk("perf_redir", perf_redir, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rv_fetch.md
Name: rv_fetch

Overview:
- Instruction fetch unit; the producer side of the decoder's instruction interface.
- Generates sequential PCs and issues word requests to instruction memory.
- Buffers in-order responses in a small FIFO and presents one instruction plus its PC per valid/ready handshake to decode.
- Handles redirects from execute (branch/jump) by flushing buffered work and discarding stale in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset.
- FIFO_DEPTH, 2, instruction buffer entries; also the maximum number of outstanding requests (power of two, >=2).

Ports:
- clk_i  input  1  clock
- rst_i  input  1  synchronous active-high reset
- imem_req_o  output  1  request valid to instruction memory
- imem_addr_o  output  32  word-aligned request address
- imem_gnt_i  input  1  request accepted this cycle
- imem_rvalid_i  input  1  response data valid; in order, at least 1 cycle after its grant
- imem_rdata_i  input  32  response instruction word
- redirect_i  input  1  one-cycle pulse: restart fetch at redirect_pc_i
- redirect_pc_i  input  32  new PC; bits[1:0] are ignored (forced to 0)
- instr_valid_o  output  1  instr_o/instr_pc_o valid toward decode
- instr_ready_i  input  1  decode accepts
- instr_o  output  32  instruction word
- instr_pc_o  output  32  PC of instr_o

Behaviour:
- Reset values:
  - imem_req_o=0, imem_addr_o=RESET_PC, instr_valid_o=0.
  - instr_o=32'h0000_0013 (NOP), instr_pc_o=0.
  - FIFO empty, outstanding=0, state IDLE.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: one cycle after reset release, no request; then go to RUN.
  - RUN: imem_req_o=1 when outstanding+fifo_count < FIFO_DEPTH. On imem_gnt_i, fetch_pc += 4 (wraps at 2^32), outstanding++, and the issued PC is pushed to an in-flight PC queue.
  - DRAIN: entered on redirect_i while outstanding>0 (excluding any response arriving that same cycle). imem_req_o=0. Each imem_rvalid_i is dropped and decrements outstanding. Go to RUN in the cycle after outstanding reaches 0.
- Request stability: imem_addr_o and imem_req_o are held stable while imem_req_o=1 and imem_gnt_i=0, unless a redirect occurs. A redirect may withdraw the pending request.
- Response handling in RUN: imem_rvalid_i pushes {imem_rdata_i, head of in-flight PC queue} into the FIFO and decrements outstanding. The credit rule guarantees the FIFO never overflows; an assertion must flag rvalid with outstanding==0.
- Output:
  - instr_valid_o = FIFO not empty; instr_o/instr_pc_o = FIFO head, registered.
  - Pop on instr_valid_o & instr_ready_i.
  - Output data holds while valid & !ready.
  - Bypass is not allowed: a response appears on the output at the earliest 1 cycle after imem_rvalid_i.
- Same-cycle push and pop: allowed; count unchanged; full FIFO + pop + push is legal.
- Redirect (highest priority):
  - An output handshake in the same cycle completes (counts as delivered).
  - All other FIFO entries are flushed; instr_valid_o=0 next cycle.
  - fetch_pc := {redirect_pc_i[31:2],2'b00}.
  - A response arriving in the redirect cycle is dropped.
  - Next state: DRAIN if outstanding (after that drop) >0, else RUN.
  - A redirect during DRAIN updates fetch_pc and remains in DRAIN.
- Latency: redirect to first new imem_req_o is 1 cycle (RUN case). Grant to output is at least 2 cycles.
- rst_i mid-operation: all state returns to reset values next cycle. Responses arriving after reset for pre-reset requests are a system error, not handled.

Optional Feature:
- Macro RV_FETCH_PERF_EN.
- Defined: adds outputs perf_stall_cnt_o[31:0] and perf_redirect_cnt_o[31:0], both reset to 0 and wrapping.
  - Stall counter increments each cycle in which instr_ready_i=1 and instr_valid_o=0 while state != IDLE.
  - Redirect counter increments on each redirect_i.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- rv_pkg gains:
  - RV_NOP_INSTR = 32'h0000_0013.
  - RV_INSTR_W = 32.
  - fetch_state_e enum {FETCH_IDLE, FETCH_RUN, FETCH_DRAIN}.
  - fetch_entry_t struct {instr, pc}.
- One sub-module, rv_fetch_fifo: synchronous FIFO of fetch_entry_t with push, pop, flush, count, full and empty. It is instantiated for the output buffer; the in-flight PC queue reuses it at the same depth.

Test Plan:
- Reset then always-grant memory with 1-cycle response and ready=1 -> addresses 0,4,8,... are issued; instr_pc_o sequence 0,4,8 with matching data; first instr_valid_o 3 cycles after reset release.
- instr_ready_i=0 for 10 cycles -> at most 2 requests are granted, imem_req_o drops, instr_o stays at PC 0. On ready=1, fetching resumes with no loss or duplication.
- imem_gnt_i held 0 for 5 cycles -> imem_addr_o stays 0x0 with req=1 throughout.
- Redirect to 32'h0000_0103 with 2 responses outstanding -> FSM enters DRAIN, both stale responses are dropped, next request address is 0x100, first delivered instr_pc_o is 0x100.
- Redirect in the same cycle as an output handshake and an imem_rvalid_i -> the handshake instruction is delivered once, the response is dropped, and instr_valid_o=0 next cycle.
- Fetch near 32'hFFFF_FFFC -> next address wraps to 0x0. With RV_FETCH_PERF_EN, perf counters match the stall and redirect counts from the scenarios above.
